// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: programmable length/count/gap, deterministic byte pattern, honours tready.
// Optional AXIS_FRAME_GEN_SEQ_EN: bytes 0..1 of each frame carry the big-endian frame number.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           frame_len,
    input  logic [15:0]           frame_count,
    input  logic [7:0]            gap_cycles,
    input  logic                  mark_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    localparam logic [15:0] KW16 = 16'(KEEP_WIDTH);

    state_t      state, state_nxt;
    logic [15:0] cfg_len, cfg_count;
    logic [7:0]  cfg_gap;
    logic        cfg_bad;
    logic [15:0] frame_idx;
    logic [15:0] byte_idx;
    logic [7:0]  gap_cnt;
    logic        stop_seen;

    logic        sending, hs, last_beat, frame_end, count_hit, end_run;
    logic [15:0] remaining;

    // byte_idx never reaches cfg_len, so remaining is always >= 1 while sending.
    assign remaining = cfg_len - byte_idx;
    assign sending   = (state == S_SEND);
    assign hs        = sending & m_axis_tready;
    assign last_beat = (remaining <= KW16);
    assign frame_end = hs & last_beat;
    assign count_hit = (cfg_count != 16'd0) && (frame_idx + 16'd1 == cfg_count);
    assign end_run   = stop_seen | stop | count_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_SEND;
            S_SEND: begin
                if (frame_end) begin
                    if (end_run)             state_nxt = S_IDLE;
                    else if (cfg_gap != 8'd0) state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (stop)                 state_nxt = S_IDLE;
                else if (gap_cnt == 8'd1) state_nxt = S_SEND;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_len     <= 16'd0;
            cfg_count   <= 16'd0;
            cfg_gap     <= 8'd0;
            cfg_bad     <= 1'b0;
            frame_idx   <= 16'd0;
            byte_idx    <= 16'd0;
            gap_cnt     <= 8'd0;
            stop_seen   <= 1'b0;
            frames_sent <= 32'd0;
            done        <= 1'b0;
        end else begin
            done <= (state != S_IDLE) && (state_nxt == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_len   <= (frame_len == 16'd0) ? 16'd1 : frame_len;
                        cfg_count <= frame_count;
                        cfg_gap   <= gap_cycles;
                        cfg_bad   <= mark_bad;
                        frame_idx <= 16'd0;
                        byte_idx  <= 16'd0;
                        stop_seen <= stop;
                    end
                end
                S_SEND: begin
                    if (stop) stop_seen <= 1'b1;
                    if (hs) begin
                        if (last_beat) begin
                            byte_idx    <= 16'd0;
                            frame_idx   <= frame_idx + 16'd1;
                            frames_sent <= frames_sent + 32'd1;
                            gap_cnt     <= cfg_gap;
                        end else begin
                            byte_idx <= byte_idx + KW16;
                        end
                    end
                end
                S_GAP:   gap_cnt <= gap_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Outputs are forced to zero outside SEND so the port reads all-zero when idle.
    for (genvar j = 0; j < KEEP_WIDTH; j++) begin : g_lane
        localparam logic [15:0] LANE = 16'(j);
        logic [7:0] lane_byte;
`ifdef AXIS_FRAME_GEN_SEQ_EN
        logic [15:0] lane_pos;
        assign lane_pos  = byte_idx + LANE;
        assign lane_byte = (cfg_len >= 16'd2 && lane_pos == 16'd0) ? frame_idx[15:8] :
                           (cfg_len >= 16'd2 && lane_pos == 16'd1) ? frame_idx[7:0]  :
                           frame_idx[7:0] + lane_pos[7:0];
`else
        assign lane_byte = frame_idx[7:0] + byte_idx[7:0] + LANE[7:0];
`endif
        assign m_axis_tdata[8*j +: 8] = sending ? lane_byte : 8'd0;
        assign m_axis_tkeep[j]        = sending && (LANE < remaining);
    end

    assign m_axis_tvalid = sending;
    assign m_axis_tlast  = sending & last_beat;
    assign m_axis_tuser  = USER_WIDTH'(sending & last_beat & cfg_bad);
    assign busy          = (state != S_IDLE);

endmodule
